// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcode/funct values,
// ALU/operand/branch/jump codes and the ID/EX control bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    // REGIMM distinguishes its branches by the rt field.
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        SRC_RT   = 2'd0,
        SRC_ZEXT = 2'd1,
        SRC_SEXT = 2'd2,
        SRC_LUI  = 2'd3
    } alu_src_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BGEZ = 3'd4
    } br_cond_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_JR   = 2'd1,
        JMP_J    = 2'd2,
        JMP_JAL  = 2'd3
    } jump_e;

    typedef struct packed {
        alu_ctrl_e alu_ctrl;
        alu_src_e  alu_src;
        br_cond_e  br_cond;
        jump_e     jump;
        logic      mem_read;
        logic      mem_write;
        logic      mem_to_reg;
        logic      reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Purely combinational instruction decoder (module mips_decode): produces the
// control bundle, destination register and which of rs/rt are read.
module mips_decode
    import mips_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr,
    output ctrl_t             ctrl,
    output logic [REG_AW-1:0] wr_addr,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic              uses_rs,
    output logic              uses_rt,
    output logic              unknown
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic       unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign rt_f         = instr[20:16];
    assign rd_f         = instr[15:11];
    assign rs           = REG_AW'(instr[25:21]);
    assign rt           = REG_AW'(rt_f);
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        wr_addr = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        unknown = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                wr_addr        = REG_AW'(rd_f);
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: ctrl.alu_ctrl = ALU_ADD;
                    F_SUB, F_SUBU: ctrl.alu_ctrl = ALU_SUB;
                    F_AND:         ctrl.alu_ctrl = ALU_AND;
                    F_OR:          ctrl.alu_ctrl = ALU_OR;
                    F_NOR:         ctrl.alu_ctrl = ALU_NOR;
                    F_SLT:         ctrl.alu_ctrl = ALU_SLT;
                    F_SLL: begin
                        ctrl.alu_ctrl = ALU_SLL;
                        uses_rs       = 1'b0;
                    end
                    F_SRL: begin
                        ctrl.alu_ctrl = ALU_SRL;
                        uses_rs       = 1'b0;
                    end
                    F_SRA: begin
                        ctrl.alu_ctrl = ALU_SRA;
                        uses_rs       = 1'b0;
                    end
                    F_JR: begin
                        ctrl.jump      = JMP_JR;
                        ctrl.reg_write = 1'b0;
                        wr_addr        = '0;
                        uses_rt        = 1'b0;
                    end
                    default: unknown = 1'b1;
                endcase
                // sll into $zero is the architectural nop and must not write.
                if (funct == F_SLL && rd_f == 5'd0) begin
                    ctrl    = CTRL_BUBBLE;
                    wr_addr = '0;
                    uses_rt = 1'b0;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                ctrl.reg_write = 1'b1;
                wr_addr        = REG_AW'(rt_f);
                uses_rs        = (opcode != OP_LUI);
                case (opcode)
                    OP_SLTI: begin
                        ctrl.alu_ctrl = ALU_SLT;
                        ctrl.alu_src  = SRC_SEXT;
                    end
                    OP_ANDI: begin
                        ctrl.alu_ctrl = ALU_AND;
                        ctrl.alu_src  = SRC_ZEXT;
                    end
                    OP_ORI: begin
                        ctrl.alu_ctrl = ALU_OR;
                        ctrl.alu_src  = SRC_ZEXT;
                    end
                    OP_LUI: begin
                        ctrl.alu_ctrl = ALU_ADD;
                        ctrl.alu_src  = SRC_LUI;
                    end
                    default: begin
                        ctrl.alu_ctrl = ALU_ADD;
                        ctrl.alu_src  = SRC_SEXT;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.alu_src    = SRC_SEXT;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                wr_addr         = REG_AW'(rt_f);
                uses_rs         = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.alu_src   = SRC_SEXT;
                ctrl.mem_write = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.br_cond  = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BGTZ: begin
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.br_cond  = BR_BGTZ;
                uses_rs       = 1'b1;
            end
            OP_REGIMM: begin
                if (rt_f == RT_BGEZ) begin
                    ctrl.alu_ctrl = ALU_SUB;
                    ctrl.br_cond  = BR_BGEZ;
                    uses_rs       = 1'b1;
                end else begin
                    unknown = 1'b1;
                end
            end
            OP_J: ctrl.jump = JMP_J;
            OP_JAL: begin
                // The link value is formed in EX as PC + ex_link.
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.jump      = JMP_JAL;
                ctrl.reg_write = 1'b1;
                wr_addr        = REG_AW'(31);
            end
            default: unknown = 1'b1;
        endcase

        // Unknown encodings never leak partial decode into the bundle.
        if (unknown) begin
            ctrl    = CTRL_BUBBLE;
            wr_addr = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control: registered ID/EX bundle, load-use stall FSM and redirect flush.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (sticky illegal flag, unknown -> bubble).
module pipe_ctrl_unit
    import mips_ctrl_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   instruction,
    input  logic              ex_redirect,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_ctrl,
    output logic [1:0]        ex_alu_src,
    output logic [2:0]        ex_br_cond,
    output logic [1:0]        ex_jump,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic [REG_AW-1:0] ex_wr_addr,
    output logic [XLEN-1:0]   ex_link,
    output logic              illegal,
    output logic [0:0]        dbg_state,
    output logic [1:0]        dbg_stall_cnt
);

    // Handshake: an instruction leaves IF/ID on a clock edge where id_valid
    // and id_ready are both 1; on a redirect it is consumed and discarded.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ex_valid_q, ex_valid_d;
    ctrl_t             ex_q, ex_d;
    logic [REG_AW-1:0] wr_q, wr_d;

    ctrl_t             dec_ctrl;
    logic [REG_AW-1:0] dec_wr, dec_rs, dec_rt;
    logic              dec_uses_rs, dec_uses_rt, dec_unknown;
    logic              hazard, accept, trap;

    mips_decode #(.REG_AW(REG_AW)) u_decode (
        .instr   (instruction[31:0]),
        .ctrl    (dec_ctrl),
        .wr_addr (dec_wr),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .uses_rs (dec_uses_rs),
        .uses_rt (dec_uses_rt),
        .unknown (dec_unknown)
    );

    assign hazard = id_valid && ex_valid_q && ex_q.mem_read && (wr_q != '0) &&
                    ((dec_uses_rs && dec_rs == wr_q) ||
                     (dec_uses_rt && dec_rt == wr_q));

    assign id_ready = ex_redirect || (state_q == ST_RUN && !hazard);
    assign accept   = id_valid && id_ready && !ex_redirect;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap = accept && dec_unknown;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ex_redirect) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (state_q == ST_STALL) begin
            // The hazard cycle itself is the first bubble, so STALL leaves at 1.
            if (cnt_q <= 2'd1) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (hazard && LOAD_USE_STALLS > 1) begin
            state_d = ST_STALL;
            cnt_d   = 2'(LOAD_USE_STALLS - 1);
        end
    end

    always_comb begin
        ex_valid_d = 1'b0;
        ex_d       = CTRL_BUBBLE;
        wr_d       = '0;
        if (accept && !trap) begin
            ex_valid_d = 1'b1;
            ex_d       = dec_unknown ? CTRL_BUBBLE : dec_ctrl;
            wr_d       = dec_unknown ? '0 : dec_wr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= CTRL_BUBBLE;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            wr_q       <= wr_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (trap) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign ex_valid      = ex_valid_q;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_br_cond    = ex_q.br_cond;
    assign ex_jump       = ex_q.jump;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_wr_addr    = wr_q;
    assign ex_link       = XLEN'(4);
    assign dbg_state     = state_q;
    assign dbg_stall_cnt = cnt_q;

endmodule
